// File: rtl/lsu_controller.sv
// -----------------------------------------------------------------------------
// lsu_controller
//
// Load/store sequencer between the execute stage and a word-organized data
// memory. It accepts one RV32I load or store per handshake and decodes funct3.
// Loads get byte/halfword extraction with sign or zero extension. SB/SH are
// done as read-modify-write, because the memory only takes full-word writes.
// Misaligned, out-of-range and illegal-funct3 requests are rejected without
// touching memory.
//
// Ports
//   clk, rst      rising-edge clock; synchronous active-high reset
//   req_valid     request present (sampled only in IDLE)
//   req_ready     high only in IDLE
//   req_we        1 = store, 0 = load
//   req_funct3    RV32I funct3
//   req_addr      byte address
//   req_wdata     store data (low byte/half used for SB/SH)
//   rsp_valid     one-cycle response pulse
//   rsp_rdata     extended load result; 0 for stores and errors
//   rsp_err       request rejected
//   mem_read      memory read enable (mem_rdata is combinational)
//   mem_write     memory write enable (memory writes on the rising edge)
//   mem_addr      word-aligned address
//   mem_wdata     full word to write
//   mem_rdata     memory read data
// -----------------------------------------------------------------------------
module lsu_controller #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    // One extra bit so the bound check is a true unsigned compare; addresses
    // near 0xFFFFFFFF must never wrap into low memory.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_t      state;
    state_t      state_next;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;     // load result, or the word to be written
    logic        err_q;

    logic        req_legal;
    logic        req_misaligned;
    logic        req_out_of_range;
    logic        req_err;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;

    // ---------------------------------------------------------------------
    // Request checks (evaluated on the raw request in IDLE)
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default first,
        // so no path can leave it unassigned and infer a latch.
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_we;  // LBU/LHU have no store form
            default:                req_legal = 1'b0;
        endcase
        // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_misaligned = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_misaligned = 1'b1;
    end

    assign req_out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign req_err          = !req_legal || req_misaligned || req_out_of_range;

    // ---------------------------------------------------------------------
    // Load extraction and store merge, both working on the current mem_rdata
    // ---------------------------------------------------------------------
    assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ---------------------------------------------------------------------
    // FSM: next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = 32'h0;
        rsp_err    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!req_we)
                        state_next = LOAD;
                    else if (req_funct3[1:0] == 2'b10)
                        state_next = WRITE;
                    else
                        state_next = RMW_READ;
                end
            end
            LOAD: begin
                mem_read   = 1'b1;
                mem_addr   = {addr_q[31:2], 2'b00};
                state_next = RESP;
            end
            RMW_READ: begin
                mem_read   = 1'b1;
                mem_addr   = {addr_q[31:2], 2'b00};
                state_next = WRITE;
            end
            WRITE: begin
                // Reset in this cycle must suppress the write, not just the
                // state update, or an aborted store would still land.
                mem_write  = !rst;
                mem_addr   = {addr_q[31:2], 2'b00};
                mem_wdata  = word_q;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid  = !rst;
                rsp_err    = err_q;
                rsp_rdata  = (we_q || err_q) ? 32'h0 : word_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Request latch and data path
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        // For SW the merged word is simply the store data.
                        word_q   <= req_wdata;
                        err_q    <= req_err;
                    end
                end
                LOAD:     word_q <= load_data;
                RMW_READ: word_q <= merged;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// -----------------------------------------------------------------------------
// tb_lsu_controller
//
// Directed bench for lsu_controller with a 256-word behavioural memory.
// Each request is issued in an IDLE cycle (cycle 0) and the following four
// cycles are observed: response cycle, data, error flag, memory activity and
// req_ready while busy.
// -----------------------------------------------------------------------------
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int n_vec = 0;
    int n_bad = 0;

    // Observations from the last request
    int          r_cyc;
    logic [31:0] r_data;
    logic        r_err;
    int          r_nrsp;
    int          r_nrd;
    int          r_nwr;
    int          r_wcyc;
    logic [31:0] r_waddr;
    int          r_both;
    int          r_busy;
    logic        r_ready0;

    lsu_controller #(.MEM_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr[9:2]] <= mem_wdata;
    end

    assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request in the current (IDLE) cycle and observe cycles 1..4.
    // Returns in cycle 4, which is always IDLE again.
    task do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        #1;
        r_ready0 = req_ready;
        r_cyc = -1;
        r_data = 32'h0;
        r_err = 1'b0;
        r_nrsp = rsp_valid ? 1 : 0;
        r_nrd = 0;
        r_nwr = 0;
        r_wcyc = -1;
        r_waddr = 32'h0;
        r_both = 0;
        r_busy = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            #1;
            if (rsp_valid) begin
                r_nrsp++;
                r_cyc = c;
                r_data = rsp_rdata;
                r_err = rsp_err;
            end
            if (mem_read) r_nrd++;
            if (mem_write) begin
                r_nwr++;
                r_wcyc = c;
                r_waddr = mem_addr;
            end
            if (mem_read && mem_write) r_both++;
            if (req_ready && (r_nrsp == 0 || r_cyc == c)) r_busy++;
        end
    endtask

    task check_rsp(input string tag, input int exp_cyc, input logic [31:0] exp_data,
                   input logic exp_err, input int exp_nrd, input int exp_nwr);
        check({tag, ".ready0"}, 32'(r_ready0), 32'd1);
        check({tag, ".nrsp"}, 32'(r_nrsp), 32'd1);
        check({tag, ".cyc"}, 32'(r_cyc), 32'(exp_cyc));
        check({tag, ".rdata"}, r_data, exp_data);
        check({tag, ".err"}, 32'(r_err), 32'(exp_err));
        check({tag, ".nrd"}, 32'(r_nrd), 32'(exp_nrd));
        check({tag, ".nwr"}, 32'(r_nwr), 32'(exp_nwr));
        check({tag, ".both"}, 32'(r_both), 32'd0);
        check({tag, ".busy"}, 32'(r_busy), 32'd0);
    endtask

    task check_idle_outputs(input string tag);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, ".mem_read"}, 32'(mem_read), 32'd0);
        check({tag, ".mem_write"}, 32'(mem_write), 32'd0);
        check({tag, ".mem_addr"}, mem_addr, 32'h0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    endtask

    int acc;
    int rsps;
    int bad_data;

    initial begin
        // Reset, with a request pending to show reset wins.
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h10;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");

        // Word path
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check_rsp("sw10", 2, 32'h0, 1'b0, 0, 1);
        check("sw10.wcyc", 32'(r_wcyc), 32'd1);
        check("sw10.waddr", r_waddr, 32'h10);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        check_rsp("lw10", 2, 32'hDEADBEEF, 1'b0, 1, 0);

        // Byte / halfword extension on 0x80FF7F01
        do_req(1'b1, 3'b010, 32'h20, 32'h80FF7F01);
        check_rsp("sw20", 2, 32'h0, 1'b0, 0, 1);
        do_req(1'b0, 3'b000, 32'h23, 32'h0);
        check_rsp("lb23", 2, 32'hFFFFFF80, 1'b0, 1, 0);
        do_req(1'b0, 3'b100, 32'h23, 32'h0);
        check_rsp("lbu23", 2, 32'h00000080, 1'b0, 1, 0);
        do_req(1'b0, 3'b001, 32'h22, 32'h0);
        check_rsp("lh22", 2, 32'hFFFF80FF, 1'b0, 1, 0);
        do_req(1'b0, 3'b101, 32'h20, 32'h0);
        check_rsp("lhu20", 2, 32'h00007F01, 1'b0, 1, 0);
        do_req(1'b0, 3'b000, 32'h21, 32'h0);
        check_rsp("lb21", 2, 32'h0000007F, 1'b0, 1, 0);
        do_req(1'b0, 3'b101, 32'h22, 32'h0);
        check_rsp("lhu22", 2, 32'h000080FF, 1'b0, 1, 0);

        // Read-modify-write
        do_req(1'b1, 3'b010, 32'h30, 32'h11223344);
        check_rsp("sw30", 2, 32'h0, 1'b0, 0, 1);
        do_req(1'b1, 3'b000, 32'h31, 32'h123456AA);
        check_rsp("sb31", 3, 32'h0, 1'b0, 1, 1);
        check("sb31.wcyc", 32'(r_wcyc), 32'd2);
        check("sb31.waddr", r_waddr, 32'h30);
        do_req(1'b0, 3'b010, 32'h30, 32'h0);
        check_rsp("lw30a", 2, 32'h1122AA44, 1'b0, 1, 0);
        do_req(1'b1, 3'b001, 32'h32, 32'h0000BEEF);
        check_rsp("sh32", 3, 32'h0, 1'b0, 1, 1);
        do_req(1'b0, 3'b010, 32'h30, 32'h0);
        check_rsp("lw30b", 2, 32'hBEEFAA44, 1'b0, 1, 0);

        // Last in-range word
        do_req(1'b1, 3'b010, 32'h3FC, 32'hA5A5C3C3);
        check_rsp("sw3fc", 2, 32'h0, 1'b0, 0, 1);
        do_req(1'b0, 3'b010, 32'h3FC, 32'h0);
        check_rsp("lw3fc", 2, 32'hA5A5C3C3, 1'b0, 1, 0);

        // Error cases: response in cycle 1, no memory access
        do_req(1'b0, 3'b010, 32'h02, 32'h0);
        check_rsp("err_lw02", 1, 32'h0, 1'b1, 0, 0);
        do_req(1'b1, 3'b001, 32'h01, 32'h1234);
        check_rsp("err_sh01", 1, 32'h0, 1'b1, 0, 0);
        do_req(1'b0, 3'b010, 32'h400, 32'h0);
        check_rsp("err_lw400", 1, 32'h0, 1'b1, 0, 0);
        do_req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0);
        check_rsp("err_wrap", 1, 32'h0, 1'b1, 0, 0);
        do_req(1'b0, 3'b011, 32'h10, 32'h0);
        check_rsp("err_ld011", 1, 32'h0, 1'b1, 0, 0);
        do_req(1'b1, 3'b100, 32'h10, 32'h55555555);
        check_rsp("err_st100", 1, 32'h0, 1'b1, 0, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        check_rsp("lw10_after_err", 2, 32'hDEADBEEF, 1'b0, 1, 0);

        // Handshake: req_valid held high, LW every 3 cycles
        acc = 0;
        rsps = 0;
        bad_data = 0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h10;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (req_ready) acc++;
            if (rsp_valid) begin
                rsps++;
                if (rsp_rdata !== 32'hDEADBEEF) bad_data++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (rsp_valid) rsps++;
            @(posedge clk);
            #1;
        end
        check("hs.accepts", 32'(acc), 32'd4);
        check("hs.responses", 32'(rsps), 32'd4);
        check("hs.rdata", 32'(bad_data), 32'd0);

        // Reset in the WRITE cycle of an SB
        do_req(1'b1, 3'b010, 32'h40, 32'h11223344);
        check_rsp("sw40", 2, 32'h0, 1'b0, 0, 1);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 32'h40;
        req_wdata = 32'h000000EE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #1;
        check("rst.rmw_read", 32'(mem_read), 32'd1);
        @(posedge clk);
        #1;
        check("rst.write_phase", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("rst.write_gated", 32'(mem_write), 32'd0);
        check("rst.no_rsp_w", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_idle_outputs("post_rst");
        @(posedge clk);
        #2;
        check("post_rst.no_rsp", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        check_rsp("lw40", 2, 32'h11223344, 1'b0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
